// File: rtl/image_frame_buffer.sv
// Dual-port pixel store: Avalon-MM CPU port for load/readback, plus a scan-out engine that
// streams the whole image as Avalon-ST with sop/eop/eol markers.
module image_frame_buffer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned DEPTH         = 58368,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned LINE_LEN      = 256,
  parameter int unsigned WRITE_PROTECT = 1,
  parameter              INIT_FILE     = "ImagemA.mif"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_chipselect,
  input  logic              s_read,
  input  logic              s_write,
  input  logic              s_debugaccess,
  input  logic [DATA_W-1:0] s_writedata,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic              s_error,
  input  logic              s_error_clr,
  input  logic              st_start,
  output logic              st_busy,
  output logic              st_done,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              st_eol
);

  localparam int unsigned   MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   LineW    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [LineW-1:0]  LineLast = LineW'(LINE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic              eol;
    logic [DATA_W-1:0] data;
  } pix_t;

  // RAM contents are loaded through the CPU port; the file name is kept for drop-in
  // compatibility with the vendor-initialised memories this block replaces.
  logic unused_init;
  assign unused_init = ^INIT_FILE;

  logic [DATA_W-1:0] mem [DEPTH];

  // CPU port decode
  logic in_range, wr_en, rd_acc, err_set, wp_on;
  assign wp_on    = (WRITE_PROTECT != 0);
  assign in_range = ({1'b0, s_address} < DepthW);
  assign wr_en    = s_chipselect & s_write & (s_debugaccess | ~wp_on) & in_range;
  assign rd_acc   = s_chipselect & s_read & ~s_write;
  assign err_set  = s_chipselect & (s_read | s_write) & ~in_range;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LineW-1:0]  line_q;
  logic              inflight_q, issue, room, scan_empty;
  logic [1:0]        fifo_cnt_q;
  pix_t              fifo_q [2];
  pix_t              b_pix, head;
  logic [DATA_W-1:0] a_rdata_q, b_data_q;
  logic              b_sop_q, b_eop_q, b_eol_q;
  logic              a_vld_q, a_oor_q;
  logic              push, fifo_pop;

  // Nonblocking reads alongside the write give read-old-data on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[s_address[MemAw-1:0]] <= s_writedata;
    a_rdata_q <= mem[s_address[MemAw-1:0]];
    if (issue) b_data_q <= mem[rd_addr_q[MemAw-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld_q         <= 1'b0;
      a_oor_q         <= 1'b0;
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
      s_error         <= 1'b0;
    end else begin
      a_vld_q         <= rd_acc;
      a_oor_q         <= ~in_range;
      s_readdatavalid <= a_vld_q;
      s_readdata      <= (a_vld_q & ~a_oor_q) ? a_rdata_q : '0;
      s_error         <= err_set | (s_error & ~s_error_clr);
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Scan FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (st_start) state_d = StRun;
      StRun:   if (issue && (rd_addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (scan_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Scan FSM: outputs. A read may only be issued if its data is guaranteed a FIFO slot.
  always_comb begin
    room       = (fifo_cnt_q == 2'd0) | ((fifo_cnt_q == 2'd1) & ~inflight_q);
    scan_empty = (fifo_cnt_q == 2'd0) & ~inflight_q;
    issue      = (state_q == StRun) & room;
    st_busy    = (state_q != StIdle);
    st_done    = (state_q == StDrain) & scan_empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q  <= '0;
      line_q     <= '0;
      inflight_q <= 1'b0;
      b_sop_q    <= 1'b0;
      b_eop_q    <= 1'b0;
      b_eol_q    <= 1'b0;
    end else begin
      inflight_q <= issue;
      if ((state_q == StIdle) && st_start) begin
        rd_addr_q <= '0;
        line_q    <= '0;
      end else if (issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        line_q    <= (line_q == LineLast) ? '0 : line_q + 1'b1;
        b_sop_q   <= (rd_addr_q == '0);
        b_eop_q   <= (rd_addr_q == LastAddr);
        b_eol_q   <= (line_q == LineLast);
      end
    end
  end

  // RAM output bypasses the empty FIFO so the first pixel is visible one cycle after issue.
  always_comb begin
    b_pix    = '{sop: b_sop_q, eop: b_eop_q, eol: b_eol_q, data: b_data_q};
    head     = (fifo_cnt_q != 2'd0) ? fifo_q[0] : b_pix;
    st_valid = (fifo_cnt_q != 2'd0) | inflight_q;
    st_data  = st_valid ? head.data : '0;
    st_sop   = st_valid & head.sop;
    st_eop   = st_valid & head.eop;
    st_eol   = st_valid & head.eol;
    fifo_pop = (fifo_cnt_q != 2'd0) & st_ready;
    push     = inflight_q & ~((fifo_cnt_q == 2'd0) & st_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt_q <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      case ({push, fifo_pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) fifo_q[0] <= b_pix;
          else                    fifo_q[1] <= b_pix;
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo_q[0]  <= fifo_q[1];
          fifo_cnt_q <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo_q[0] <= b_pix;
          end else begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= b_pix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_frame_buffer.sv
// Directed self-checking bench for image_frame_buffer: CPU port, protection, range errors,
// full-rate scan, backpressured scan and reset mid-scan.
module tb_image_frame_buffer;

  localparam int DW  = 8;
  localparam int DEP = 512;
  localparam int AW  = 16;
  localparam int LL  = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] s_address;
  logic          s_chipselect, s_read, s_write, s_debugaccess, s_error_clr;
  logic [DW-1:0] s_writedata, s_readdata;
  logic          s_readdatavalid, s_error;
  logic          st_start, st_busy, st_done, st_valid, st_ready, st_sop, st_eop, st_eol;
  logic [DW-1:0] st_data;

  logic [DW-1:0] model [DEP];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  image_frame_buffer #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .LINE_LEN(LL), .WRITE_PROTECT(1),
    .INIT_FILE("ImagemA.mif")
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_debugaccess(s_debugaccess), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_error(s_error), .s_error_clr(s_error_clr),
    .st_start(st_start), .st_busy(st_busy), .st_done(st_done), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop),
    .st_eol(st_eol)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    s_chipselect  = 1'b0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_debugaccess = 1'b0;
    s_error_clr   = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dbg);
    s_chipselect  = 1'b1;
    s_write       = 1'b1;
    s_address     = a;
    s_writedata   = d;
    s_debugaccess = dbg;
    step();
    idle_bus();
  endtask

  task automatic cpu_read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                                input string name);
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    s_address    = a;
    step();
    idle_bus();
    n_tests++;
    if (s_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: valid=%b required 0", name, s_readdatavalid);
    end
    step();
    n_tests++;
    if (s_readdatavalid !== 1'b1 || s_readdata !== exp) begin
      n_fail++;
      $display("FAIL %s: valid=%b data=%h required valid=1 data=%h",
               name, s_readdatavalid, s_readdata, exp);
    end
    step();
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({s_readdatavalid, s_error, st_busy, st_done, st_valid, st_sop, st_eop, st_eol} !== 8'h00
        || s_readdata !== '0 || st_data !== '0) begin
      n_fail++;
      $display("FAIL %s: flags=%b rdata=%h st_data=%h required all 0", name,
               {s_readdatavalid, s_error, st_busy, st_done, st_valid, st_sop, st_eop, st_eol},
               s_readdata, st_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_bus();
    s_address   = '0;
    s_writedata = '0;
    st_start    = 1'b0;
    st_ready    = 1'b0;
    repeat (3) step();
    check_all_zero("reset_state");
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_cpu_write_read();
    cpu_write(16'd10, 8'hA5, 1'b1);
    model[10] = 8'hA5;
    cpu_read_check(16'd10, 8'hA5, "rd_after_write");
  endtask

  task automatic test_write_protect();
    cpu_write(16'd10, 8'h3C, 1'b0);
    cpu_read_check(16'd10, 8'hA5, "protected_write");
    n_tests++;
    if (s_error !== 1'b0) begin
      n_fail++;
      $display("FAIL protect_no_error: s_error=%b required 0", s_error);
    end
  endtask

  task automatic test_out_of_range();
    cpu_write(16'd58368, 8'h77, 1'b1);
    n_tests++;
    if (s_error !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write_error: s_error=%b required 1", s_error);
    end
    cpu_read_check(16'd58368, 8'h00, "oor_read");
    s_error_clr = 1'b1;
    step();
    s_error_clr = 1'b0;
    n_tests++;
    if (s_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: s_error=%b required 0", s_error);
    end
    // Clear and a fresh error in the same cycle: the error must win.
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    s_address    = 16'd600;
    s_error_clr  = 1'b1;
    step();
    idle_bus();
    n_tests++;
    if (s_error !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_new_error: s_error=%b required 1", s_error);
    end
    step();
    step();
    s_error_clr = 1'b1;
    step();
    s_error_clr = 1'b0;
  endtask

  task automatic test_pipelined_reads();
    cpu_write(16'd20, 8'h11, 1'b1);
    cpu_write(16'd21, 8'h22, 1'b1);
    model[20] = 8'h11;
    model[21] = 8'h22;
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    s_address    = 16'd20;
    step();
    s_address = 16'd21;
    step();
    n_tests++;
    if (s_readdatavalid !== 1'b1 || s_readdata !== 8'h11) begin
      n_fail++;
      $display("FAIL pipe_rd0: valid=%b data=%h required 1/11", s_readdatavalid, s_readdata);
    end
    // Write and read together: write wins, read produces no response.
    s_write       = 1'b1;
    s_address     = 16'd22;
    s_writedata   = 8'h33;
    s_debugaccess = 1'b1;
    step();
    idle_bus();
    model[22] = 8'h33;
    n_tests++;
    if (s_readdatavalid !== 1'b1 || s_readdata !== 8'h22) begin
      n_fail++;
      $display("FAIL pipe_rd1: valid=%b data=%h required 1/22", s_readdatavalid, s_readdata);
    end
    step();
    n_tests++;
    if (s_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_priority: valid=%b required 0", s_readdatavalid);
    end
    cpu_read_check(16'd22, 8'h33, "write_priority_data");
  endtask

  task automatic preload();
    for (int i = 0; i < DEP; i++) begin
      model[i] = 8'((i * 7 + 3) & 255);
      cpu_write(AW'(i), model[i], 1'b1);
    end
  endtask

  // Full-rate scan; also writes pixel 300 in the same cycle the scan reads it.
  task automatic test_scan_full();
    logic [2:0]    exp_f;
    logic [DW-1:0] new300;
    new300   = ~model[300];
    st_ready = 1'b1;
    st_start = 1'b1;
    step();
    st_start = 1'b0;
    n_tests++;
    if (st_valid !== 1'b0 || st_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_start+1: valid=%b busy=%b required 0/1", st_valid, st_busy);
    end
    step();
    for (int p = 0; p < DEP; p++) begin
      if (p == 299) begin
        s_chipselect  = 1'b1;
        s_write       = 1'b1;
        s_address     = 16'd300;
        s_writedata   = new300;
        s_debugaccess = 1'b1;
      end else begin
        idle_bus();
      end
      exp_f = {p == 0, p == DEP - 1, (p % LL) == LL - 1};
      n_tests++;
      if (st_valid !== 1'b1 || st_data !== model[p] || {st_sop, st_eop, st_eol} !== exp_f
          || st_done !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_pix%0d: v=%b d=%h sop/eop/eol=%b done=%b required 1/%h/%b/0",
                 p, st_valid, st_data, {st_sop, st_eop, st_eol}, st_done, model[p], exp_f);
      end
      step();
    end
    idle_bus();
    n_tests++;
    if (st_done !== 1'b1 || st_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_done: done=%b valid=%b required 1/0", st_done, st_valid);
    end
    step();
    n_tests++;
    if (st_done !== 1'b0 || st_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_idle: done=%b busy=%b required 0/0", st_done, st_busy);
    end
    model[300] = new300;
    cpu_read_check(16'd300, new300, "collision_write");
  endtask

  task automatic test_backpressure();
    int            idx, cyc;
    logic          stalled;
    logic [DW+2:0] held;
    logic [2:0]    exp_f;
    idx      = 0;
    stalled  = 1'b0;
    held     = '0;
    st_ready = 1'b0;
    st_start = 1'b1;
    step();
    st_start = 1'b0;
    for (cyc = 0; cyc < 5000 && idx < DEP; cyc++) begin
      st_ready = 1'($urandom_range(0, 1));
      st_start = (cyc == 40);
      if (stalled) begin
        n_tests++;
        if (st_valid !== 1'b1 || {st_data, st_sop, st_eop, st_eol} !== held) begin
          n_fail++;
          $display("FAIL bp_stable: v=%b got %h required %h", st_valid,
                   {st_data, st_sop, st_eop, st_eol}, held);
        end
      end
      if (st_valid === 1'b1 && st_ready) begin
        exp_f = {idx == 0, idx == DEP - 1, (idx % LL) == LL - 1};
        n_tests++;
        if (st_data !== model[idx] || {st_sop, st_eop, st_eol} !== exp_f || st_done !== 1'b0)
        begin
          n_fail++;
          $display("FAIL bp_pix%0d: d=%h flags=%b done=%b required %h/%b/0", idx, st_data,
                   {st_sop, st_eop, st_eol}, st_done, model[idx], exp_f);
        end
        idx++;
      end
      stalled = (st_valid === 1'b1) && !st_ready;
      held    = {st_data, st_sop, st_eop, st_eol};
      step();
    end
    st_start = 1'b0;
    st_ready = 1'b0;
    n_tests++;
    if (idx != DEP || st_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_complete: pixels=%0d done=%b required %0d/1", idx, st_done, DEP);
    end
    step();
    n_tests++;
    if (st_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: busy=%b required 0", st_busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    st_ready = 1'b1;
    st_start = 1'b1;
    step();
    st_start = 1'b0;
    repeat (101) step();
    n_tests++;
    if (st_valid !== 1'b1 || st_data !== model[100]) begin
      n_fail++;
      $display("FAIL mid_scan_pix100: v=%b d=%h required 1/%h", st_valid, st_data, model[100]);
    end
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_reset_mid_scan");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (st_busy !== 1'b0 || st_valid !== 1'b0 || st_done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle%0d: busy=%b valid=%b done=%b required 0/0/0",
                 i, st_busy, st_valid, st_done);
      end
    end
    st_start = 1'b1;
    step();
    st_start = 1'b0;
    step();
    n_tests++;
    if (st_valid !== 1'b1 || st_sop !== 1'b1 || st_data !== model[0]) begin
      n_fail++;
      $display("FAIL restart_pix0: v=%b sop=%b d=%h required 1/1/%h",
               st_valid, st_sop, st_data, model[0]);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_write_protect();
    test_out_of_range();
    test_pipelined_reads();
    preload();
    test_scan_full();
    test_backpressure();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
